// File: rtl/bin_to_bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin_to_bcd_pkg;

  // Converter control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Double-dabble digit correction: digits at or above 5 get 3 added
  // before the shift so that the doubling carries correctly into the next digit.
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

  // The counter has to hold the value bin_w itself, not just bin_w-1.
  function automatic int cnt_width(input int bin_w);
    return $clog2(bin_w + 1);
  endfunction

endpackage

// File: rtl/bin_to_bcd_digit_adj.sv
// One BCD digit correction cell. It adds 3 when the digit is 5 or more.
// Inputs never exceed 9, so the 4-bit sum cannot wrap.
module bcd_digit_adj
  import bin_to_bcd_pkg::*;
(
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  // Conditional add-3 applied ahead of each doubling step.
  always_comb begin
    digit_out = digit_in;
    if (digit_in >= BCD_ADJ_THRESH) begin
      digit_out = digit_in + BCD_ADJ_ADD;
    end
  end

endmodule

// File: rtl/bin_to_bcd.sv
// Multicycle binary-to-BCD converter (shift-and-add-3, one bit per clock).
//
// Handshake: start is looked at only while the converter is idle. A start
// seen in any other state is dropped; nothing is queued. done is a
// one-cycle pulse, and bcd_out holds the result from that cycle until the
// next done or reset. busy covers the active conversion and the done cycle.
module bin_to_bcd
  import bin_to_bcd_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  busy,
  output logic                  done
);

  localparam int SW = 4 * DIGITS;
  localparam int CW = cnt_width(BIN_W);
  localparam logic [CW-1:0] LAST = CW'(BIN_W);

  state_t            state;
  state_t            state_next;
  logic [CW-1:0]     cnt;
  logic [BIN_W-1:0]  shreg;
  logic [SW-1:0]     scratch;
  logic [SW-1:0]     adj;
  logic              finishing;

  // Every scratch digit goes through its own correction cell.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_in  (scratch[4*g +: 4]),
      .digit_out (adj[4*g +: 4])
    );
  end

  // After all BIN_W shifts the converter spends one more SHIFT cycle.
  // In that cycle it publishes the scratch value and does not shift.
  assign finishing = (state == ST_SHIFT) && (cnt == LAST);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = ST_SHIFT;
      ST_SHIFT: if (cnt == LAST) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Datapath: capture on an accepted start, then adjust-and-shift once per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg   <= '0;
      scratch <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            shreg   <= bin_in;
            scratch <= '0;
            cnt     <= '0;
          end
        end
        ST_SHIFT: begin
          if (cnt != LAST) begin
            scratch <= (adj << 1) | SW'(shreg[BIN_W-1]);
            shreg   <= shreg << 1;
            cnt     <= cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Registered outputs. bcd_out changes only when the result is published.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcd_out <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= finishing;
      busy <= (state != ST_IDLE) && (state_next != ST_IDLE);
      if (finishing) begin
        bcd_out <= scratch;
      end
    end
  end

endmodule

// File: tb/tb_bin_to_bcd.sv
// Self-checking bench for bin_to_bcd: reference model, per-cycle compare,
// and directed vectors with hand-computed results.
module tb_bin_to_bcd;

  localparam int BIN_W  = 16;
  localparam int DIGITS = 5;
  localparam int SW     = 4 * DIGITS;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [BIN_W-1:0] bin_in = '0;
  logic [SW-1:0]    bcd_out;
  logic             busy;
  logic             done;

  always #5 clk = ~clk;

  bin_to_bcd #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .bin_in  (bin_in),
    .bcd_out (bcd_out),
    .busy    (busy),
    .done    (done)
  );

  // Decimal digits by plain arithmetic.
  function automatic logic [SW-1:0] to_bcd(input int v);
    logic [SW-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  // ---------------- reference model ----------------
  // age counts edges since the accepting edge. It is -1 while idle.
  // The result appears 17 edges after acceptance, and the converter is
  // idle again one edge later.
  logic [SW-1:0] exp_q[$];
  int            age = -1;
  logic [SW-1:0] exp_bcd = '0;
  logic          exp_busy = 1'b0;
  logic          exp_done = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q.delete();
      age      <= -1;
      exp_bcd  <= '0;
      exp_busy <= 1'b0;
      exp_done <= 1'b0;
    end else if (age < 0) begin
      exp_busy <= 1'b0;
      exp_done <= 1'b0;
      if (start) begin
        exp_q.push_back(to_bcd(int'(bin_in)));
        age <= 0;
      end
    end else begin
      age      <= (age + 1 == 18) ? -1 : age + 1;
      exp_busy <= (age + 1 <= 17);
      exp_done <= (age + 1 == 17);
      if (age + 1 == 17 && exp_q.size() != 0) begin
        exp_bcd <= exp_q.pop_front();
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] req;
  } lit_t;

  lit_t lits[128];
  int   n_lits = 0;
  int   lits_seen = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Compare DUT outputs against the model every cycle, plus queued literal checks.
  always @(negedge clk) begin
    chk("bcd_out", 32'(bcd_out), 32'(exp_bcd));
    chk("busy",    32'(busy),    32'(exp_busy));
    chk("done",    32'(done),    32'(exp_done));
    while (lits_seen < n_lits) begin
      chk(lits[lits_seen].name, lits[lits_seen].act, lits[lits_seen].req);
      lits_seen++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic post(input string name, input logic [31:0] act, input logic [31:0] req);
    if (n_lits < 128) begin
      lits[n_lits] = '{name, act, req};
      n_lits++;
    end
  endtask

  // Counts edges after the accepting edge until done is seen, bounded at 40.
  task automatic wait_done(output int lat, output int busy_n);
    lat = 0;
    busy_n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (busy) busy_n++;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  // Waits for idle (two negedges clear the done cycle), pulses start for one edge,
  // then checks latency and the result.
  task automatic convert(input logic [BIN_W-1:0] v, input logic [SW-1:0] lit, input string tag);
    int lat;
    int bn;
    repeat (2) @(negedge clk);
    start  = 1'b1;
    bin_in = v;
    @(negedge clk);
    start  = 1'b0;
    wait_done(lat, bn);
    post({tag, "_latency"}, 32'(lat), 32'd17);
    post({tag, "_bcd"}, 32'(bcd_out), 32'(lit));
    post({tag, "_model_pin"}, 32'(to_bcd(int'(v))), 32'(lit));
  endtask

  logic [BIN_W-1:0] bnd_in  [6] = '{16'd9, 16'd10, 16'd99, 16'd100, 16'd9999, 16'd10000};
  logic [SW-1:0]    bnd_exp [6] = '{20'h00009, 20'h00010, 20'h00099, 20'h00100, 20'h09999, 20'h10000};

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int bn;
    int seen_done;
    int n_done;

    #1 reset = 1'b1;
    #1;
    post("rst_bcd",  32'(bcd_out), 32'd0);
    post("rst_busy", 32'(busy),    32'd0);
    post("rst_done", 32'(done),    32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Zero: latency 17, busy for exactly 17 cycles.
    repeat (2) @(negedge clk);
    start = 1'b1;
    bin_in = 16'd0;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bn);
    post("zero_latency", 32'(lat), 32'd17);
    post("zero_busy_cycles", 32'(bn), 32'd17);
    post("zero_bcd", 32'(bcd_out), 32'h00000);

    convert(16'd65535, 20'h65535, "max");
    convert(16'd1234,  20'h01234, "v1234");
    for (int i = 0; i < 6; i++) begin
      convert(bnd_in[i], bnd_exp[i], $sformatf("bnd%0d", i));
    end

    // 500 with start re-pulsed at cycles 5 and 17, bin_in moved to 777.
    repeat (2) @(negedge clk);
    start = 1'b1;
    bin_in = 16'd500;
    @(negedge clk);
    start = 1'b0;
    bin_in = 16'd777;
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    post("ignore_done", 32'(done), 32'd1);
    post("ignore_bcd", 32'(bcd_out), 32'h00500);
    // The first IDLE cycle accepts a new request.
    @(negedge clk);
    start = 1'b1;
    bin_in = 16'd4321;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bn);
    post("reaccept_latency", 32'(lat), 32'd17);
    post("reaccept_bcd", 32'(bcd_out), 32'h04321);

    // Reset in the middle of a conversion.
    convert(16'd42, 20'h00042, "v42");
    repeat (2) @(negedge clk);
    start = 1'b1;
    bin_in = 16'd300;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    post("midrst_bcd",  32'(bcd_out), 32'd0);
    post("midrst_busy", 32'(busy),    32'd0);
    post("midrst_done", 32'(done),    32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (done) seen_done++;
    end
    post("midrst_no_done", 32'(seen_done), 32'd0);
    convert(16'd12345, 20'h12345, "after_rst");

    // start held high with an incrementing bin_in.
    @(negedge clk);
    start = 1'b1;
    bin_in = 16'd1000;
    n_done = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) n_done++;
      bin_in = bin_in + 16'd7;
    end
    start = 1'b0;
    post("cont_done_count", 32'(n_done), 32'd3);
    repeat (25) @(negedge clk);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
